iic_target_regfile: RTL and testbench
=====================================

// Module: iic_target_regfile
// PURPOSE
//  I2C target (responder) on the board IIC bus, the far end of the AT93C46_IIC master.
//  Decodes START/STOP, matches its 7-bit device address, ACKs, and maps I2C byte
//  writes/reads onto a simple synchronous register-file port with an auto-incrementing
//  8-bit word pointer. Lets the FPGA answer configuration reads from the on-board IIC master.
// PARAMETERS
//  DEV_AD      7'b101_0000  device address this target answers to
//  FILTER_LEN  3            samples SCL/SDA must hold before a level change is accepted (1..8)
//  HOLD_CYC    8'd60        CLK_IN cycles after SCL falling edge before SDA_OE may change (300 ns at 200 MHz)
// PORTS
//  CLK_IN        in   1  system clock (200 MHz)
//  SYS_RSTn      in   1  asynchronous active-low reset
//  IIC_SCL_IN    in   1  bus SCL level (asynchronous)
//  IIC_SDA_IN    in   1  bus SDA level (asynchronous)
//  IIC_SDA_OE    out  1  1 = pull SDA low (open-drain enable); 0 = release
//  MEM_ADDR      out  8  register address (= word pointer)
//  MEM_WD        out  8  write data
//  MEM_WE        out  1  one-cycle write strobe
//  MEM_RE        out  1  one-cycle read strobe
//  MEM_RD        in   8  read data, valid exactly 1 cycle after MEM_RE
//  BUSY_OUT      out  1  high from address-match ACK until STOP/START
// BEHAVIOUR
//  Reset: IIC_SDA_OE=0, MEM_WE=0, MEM_RE=0, MEM_ADDR=0, MEM_WD=0, BUSY_OUT=0, state IDLE, pointer 0.
//  Input path: 2-FF synchroniser, then filter: level accepted after FILTER_LEN equal samples.
//  START = filtered SDA 1->0 while SCL=1; STOP = SDA 0->1 while SCL=1. Detected in any state.
//  Bits sampled on filtered SCL rising edge, MSB first. SDA_OE updated HOLD_CYC cycles after SCL falling edge.
//  States: IDLE, DEV, DEV_ACK, WADR, WADR_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK.
//   IDLE     : wait START -> DEV.
//   DEV      : shift 8 bits; address == DEV_AD -> DEV_ACK, else IDLE (no ACK, bus ignored to next START).
//   DEV_ACK  : drive SDA low for ACK clock; BUSY_OUT=1; R/W=0 -> WADR; R/W=1 -> MEM_RE at pointer, -> RDAT.
//   WADR     : 8 bits -> pointer; -> WADR_ACK (ACK) -> WDAT.
//   WDAT     : 8 bits -> MEM_WD, MEM_ADDR=pointer, MEM_WE pulse 1 cycle at 8th SCL rise; -> WDAT_ACK (ACK);
//              pointer+1 after strobe -> WDAT.
//   RDAT     : MEM_RD latched 1 cycle after MEM_RE; shift out MSB first (OE=~bit); after 8th bit release
//              SDA -> RDAT_ACK.
//   RDAT_ACK : sample master bit on SCL rise; 0 (ACK) -> pointer+1, MEM_RE, -> RDAT; 1 (NACK) -> IDLE,
//              SDA released.
//  Pointer: 8-bit, wraps 0xFF -> 0x00; retained across transactions (random read via repeated START).
//  STOP in any state: -> IDLE, SDA_OE=0 and BUSY_OUT=0 within 1 cycle of detection; a byte cut short is
//   discarded (no MEM_WE). START in any state: same cleanup, -> DEV (repeated START).
//  MEM_WE and MEM_RE never both high; each is exactly one cycle per byte.
//  Reset mid-transfer: asynchronous return to reset values; SDA released immediately.
// TESTING
//  1 Write A0 05 11 22 P -> ACK on all 3 bytes; MEM_WE at addr 05 WD=11, addr 06 WD=22; pointer=07.
//  2 Write A0 03, Sr, A1, read 2 bytes ACK/NACK, P, MEM_RD=44,55 -> MEM_RE at 03,04; bus sees 44,55;
//    SDA released after NACK.
//  3 Address A4 with DEV_AD=50 -> no ACK (SDA_OE=0 all bytes), no MEM strobes, BUSY_OUT=0.
//  4 Pointer FF, write 2 data bytes -> MEM_WE at FF then 00.
//  5 STOP after 4 bits of data byte -> no MEM_WE, IDLE, SDA_OE=0; 1-cycle SDA glitch at FILTER_LEN=3 ignored.
//  6 SYS_RSTn low during read ACK drive -> SDA_OE=0 same cycle; next transfer with pointer 0 works.

Source files
------------

// File: rtl/iic_target_regfile_if.sv
// Bus bundle between the I2C target and its surroundings: the open-drain
// IIC pins on one side and the synchronous register-file port on the other.
interface iic_target_regfile_if;
    logic       IIC_SCL_IN;
    logic       IIC_SDA_IN;
    logic       IIC_SDA_OE;
    logic [7:0] MEM_ADDR;
    logic [7:0] MEM_WD;
    logic       MEM_WE;
    logic       MEM_RE;
    logic [7:0] MEM_RD;
    logic       BUSY_OUT;

    modport slave (
        input  IIC_SCL_IN, IIC_SDA_IN, MEM_RD,
        output IIC_SDA_OE, MEM_ADDR, MEM_WD, MEM_WE, MEM_RE, BUSY_OUT
    );

    modport master (
        output IIC_SCL_IN, IIC_SDA_IN, MEM_RD,
        input  IIC_SDA_OE, MEM_ADDR, MEM_WD, MEM_WE, MEM_RE, BUSY_OUT
    );
endinterface

// File: rtl/iic_target_regfile.sv
// I2C target that maps bus byte writes/reads onto a register-file port
// through an auto-incrementing 8-bit word pointer.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | bus ignored until START
// ST_DEV      | shifting in device address + R/W
// ST_DEV_ACK  | driving address ACK; read issues MEM_RE on the ACK clock
// ST_WADR     | shifting in word pointer
// ST_WADR_ACK | driving pointer ACK
// ST_WDAT     | shifting in write data; 8th bit fires MEM_WE
// ST_WDAT_ACK | driving data ACK
// ST_RDAT     | shifting out read data, MSB first
// ST_RDAT_ACK | sampling master ACK/NACK
module iic_target_regfile #(
    parameter logic [6:0] DEV_AD     = 7'b101_0000,
    parameter int         FILTER_LEN = 3,
    parameter logic [7:0] HOLD_CYC   = 8'd60
) (
    input logic                 CLK_IN,
    input logic                 SYS_RSTn,
    iic_target_regfile_if.slave bus
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV, ST_DEV_ACK, ST_WADR, ST_WADR_ACK,
        ST_WDAT, ST_WDAT_ACK, ST_RDAT, ST_RDAT_ACK
    } state_t;

    localparam logic [2:0] FLT_TC    = 3'(FILTER_LEN - 1);
    // A zero hold would never expire on a down-counter that fires at 1.
    localparam logic [7:0] HOLD_LOAD = (HOLD_CYC == 8'd0) ? 8'd1 : HOLD_CYC;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      flt_q, flt_d;
    logic [1:0]      flt_prev_q, flt_prev_d;
    logic [1:0][2:0] fcnt_q, fcnt_d;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] wd_q, wd_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic       re_dly_q, re_dly_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic [7:0] hold_q, hold_d;

    logic       scl, sda, scl_prev, sda_prev;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;
    logic       oe_sel;

    assign scl       = flt_q[0];
    assign sda       = flt_q[1];
    assign scl_prev  = flt_prev_q[0];
    assign sda_prev  = flt_prev_q[1];
    assign scl_rise  = scl & ~scl_prev;
    assign scl_fall  = ~scl & scl_prev;
    assign start_det = ~sda & sda_prev & scl & scl_prev;
    assign stop_det  = sda & ~sda_prev & scl & scl_prev;
    assign rx_byte   = {rx_q[6:0], sda};

    // SDA level to present once the hold time after SCL fall has elapsed.
    assign oe_sel = (state_q == ST_DEV_ACK) || (state_q == ST_WADR_ACK) ||
                    (state_q == ST_WDAT_ACK) || ((state_q == ST_RDAT) && !tx_q[7]);

    assign bus.IIC_SDA_OE = oe_q;
    assign bus.MEM_ADDR   = ptr_q;
    assign bus.MEM_WD     = wd_q;
    assign bus.MEM_WE     = we_q;
    assign bus.MEM_RE     = re_q;
    assign bus.BUSY_OUT   = busy_q;

    // Synchronise the pins, then accept a new level only after FILTER_LEN equal samples.
    always_comb begin
        sync1_d    = {bus.IIC_SDA_IN, bus.IIC_SCL_IN};
        sync2_d    = sync1_q;
        flt_d      = flt_q;
        flt_prev_d = flt_q;
        fcnt_d     = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == flt_q[i]) begin
                fcnt_d[i] = FLT_TC;
            end else if (fcnt_q[i] == 3'd0) begin
                flt_d[i]  = sync2_q[i];
                fcnt_d[i] = FLT_TC;
            end else begin
                fcnt_d[i] = fcnt_q[i] - 3'd1;
            end
        end
    end

    // Input path registers; the bus idles high.
    always_ff @(posedge CLK_IN or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            flt_q      <= 2'b11;
            flt_prev_q <= 2'b11;
            fcnt_q     <= {FLT_TC, FLT_TC};
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            flt_q      <= flt_d;
            flt_prev_q <= flt_prev_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // Protocol FSM, SDA hold timer and register-file strobes.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        re_dly_d  = re_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        hold_d    = hold_q;

        // MEM_RD is valid the cycle after MEM_RE; the pointer advances after each write.
        if (re_dly_q) tx_d = bus.MEM_RD;
        if (we_q)     ptr_d = ptr_q + 8'd1;

        if (scl_fall) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
            if (hold_q == 8'd1) oe_d = oe_sel;
        end

        if (scl_rise) begin
            case (state_q)
                ST_DEV: begin
                    rx_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (rx_byte[7:1] == DEV_AD) begin
                            state_d = ST_DEV_ACK;
                            rw_d    = rx_byte[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DEV_ACK: begin
                    bit_cnt_d = 3'd0;
                    if (rw_q) begin
                        state_d = ST_RDAT;
                        re_d    = 1'b1;
                    end else begin
                        state_d = ST_WADR;
                    end
                end
                ST_WADR: begin
                    rx_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        ptr_d   = rx_byte;
                        state_d = ST_WADR_ACK;
                    end
                end
                ST_WADR_ACK, ST_WDAT_ACK: begin
                    bit_cnt_d = 3'd0;
                    state_d   = ST_WDAT;
                end
                ST_WDAT: begin
                    rx_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        wd_d    = rx_byte;
                        we_d    = 1'b1;
                        state_d = ST_WDAT_ACK;
                    end
                end
                ST_RDAT: begin
                    tx_d      = {tx_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_RDAT_ACK;
                end
                ST_RDAT_ACK: begin
                    bit_cnt_d = 3'd0;
                    if (!sda) begin
                        ptr_d   = ptr_q + 8'd1;
                        re_d    = 1'b1;
                        state_d = ST_RDAT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end

        // START/STOP abort whatever is in flight; a partial byte never strobes.
        if (start_det || stop_det) begin
            state_d   = start_det ? ST_DEV : ST_IDLE;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            hold_d    = 8'd0;
            we_d      = 1'b0;
            re_d      = 1'b0;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge CLK_IN or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'd0;
            tx_q      <= 8'd0;
            rw_q      <= 1'b0;
            ptr_q     <= 8'd0;
            wd_q      <= 8'd0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            re_dly_q  <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            hold_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            we_q      <= we_d;
            re_q      <= re_d;
            re_dly_q  <= re_dly_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_iic_target_regfile.sv
// Bench for iic_target_regfile: bit-banged I2C master, register-file
// responder, and a transaction-level model of pointer and memory contents.
module tb_iic_target_regfile;

    localparam int T = 80;  // SCL half period in clock cycles

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_bus;

    iic_target_regfile_if bus ();

    iic_target_regfile dut (
        .CLK_IN  (clk),
        .SYS_RSTn(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign sda_bus        = m_sda & ~bus.IIC_SDA_OE;
    assign bus.IIC_SDA_IN = sda_bus;
    assign bus.IIC_SCL_IN = m_scl;

    // Register file the target talks to
    logic [7:0] rf [256];
    logic [7:0] rd_q;
    logic       load_en = 1'b0;
    logic [7:0] load_a, load_d;
    assign bus.MEM_RD = rd_q;

    always @(posedge clk) begin
        if (load_en)    rf[load_a] <= load_d;
        if (bus.MEM_WE) rf[bus.MEM_ADDR] <= bus.MEM_WD;
        if (bus.MEM_RE) rd_q <= rf[bus.MEM_ADDR];
    end

    // Observed strobes
    logic [15:0] got_we[$];
    logic [7:0]  got_re[$];
    int          viol = 0;
    logic        prev_we = 1'b0, prev_re = 1'b0;
    logic        oe_seen = 1'b0, busy_seen = 1'b0, strobe_seen = 1'b0;

    always @(negedge clk) begin
        if (bus.MEM_WE) got_we.push_back({bus.MEM_ADDR, bus.MEM_WD});
        if (bus.MEM_RE) got_re.push_back(bus.MEM_ADDR);
        if ((bus.MEM_WE && bus.MEM_RE) || (bus.MEM_WE && prev_we) || (bus.MEM_RE && prev_re)) viol++;
        prev_we = bus.MEM_WE;
        prev_re = bus.MEM_RE;
        if (bus.IIC_SDA_OE) oe_seen = 1'b1;
        if (bus.BUSY_OUT)   busy_seen = 1'b1;
        if (bus.MEM_WE || bus.MEM_RE) strobe_seen = 1'b1;
    end

    // Reference model
    logic [7:0]  ref_mem [256];
    int          m_ptr = 0;
    logic [15:0] exp_we[$];
    logic [7:0]  exp_re[$];
    logic [7:0]  wdat[$];

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        load_a = a; load_d = d; load_en = 1'b1;
        wclk(1);
        load_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wclk(T);
        m_scl = 1'b1; wclk(T);
        m_sda = 1'b0; wclk(T);
        m_scl = 1'b0; wclk(4);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wclk(T);
        m_scl = 1'b1; wclk(T);
        m_sda = 1'b1; wclk(T);
    endtask

    // One SCL clock from low to low; optional one-cycle SDA glitch while SCL is high.
    task automatic bus_bit(input logic b, input logic glitch, output logic r);
        m_sda = b; wclk(T);
        m_scl = 1'b1; wclk(T / 4);
        if (glitch) begin
            m_sda = ~b; wclk(1); m_sda = b;
        end
        wclk(T / 4);
        r = sda_bus; wclk(T / 2);
        m_scl = 1'b0; wclk(4);
    endtask

    task automatic wr_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], i == glitch_bit, r);
        bus_bit(1'b1, 1'b0, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic last, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, r);
            b[i] = r;
        end
        bus_bit(last, 1'b0, r);
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_we_cnt"}, got_we.size(), exp_we.size());
        for (int i = 0; i < got_we.size() && i < exp_we.size(); i++)
            chk({tag, "_we_addr_data"}, got_we[i], exp_we[i]);
        chk({tag, "_re_cnt"}, got_re.size(), exp_re.size());
        for (int i = 0; i < got_re.size() && i < exp_re.size(); i++)
            chk({tag, "_re_addr"}, got_re[i], exp_re[i]);
        got_we.delete(); exp_we.delete();
        got_re.delete(); exp_re.delete();
    endtask

    // S A0 <addr> <wdat...> [partial bits] P
    task automatic do_write(input string tag, input logic [7:0] a, input int glitch_bit,
                            input int partial);
        logic ack, r;
        bus_start();
        wr_byte(8'hA0, -1, ack);
        chk({tag, "_dev_ack"}, ack, 1);
        chk({tag, "_busy_on"}, bus.BUSY_OUT, 1);
        wr_byte(a, -1, ack);
        chk({tag, "_ptr_ack"}, ack, 1);
        m_ptr = a;
        for (int i = 0; i < wdat.size(); i++) begin
            wr_byte(wdat[i], (i == 0) ? glitch_bit : -1, ack);
            chk({tag, "_data_ack"}, ack, 1);
            exp_we.push_back({8'(m_ptr), wdat[i]});
            ref_mem[m_ptr] = wdat[i];
            m_ptr = (m_ptr + 1) % 256;
        end
        for (int i = 0; i < partial; i++) bus_bit(i[0], 1'b0, r);
        bus_stop();
        chk({tag, "_oe_idle"}, bus.IIC_SDA_OE, 0);
        chk({tag, "_busy_off"}, bus.BUSY_OUT, 0);
        check_events(tag);
    endtask

    // [S A0 <addr> Sr] or S, then A1, n bytes (ACK..., NACK), P
    task automatic do_read(input string tag, input logic set_addr, input logic [7:0] a, input int n);
        logic       ack;
        logic [7:0] b;
        bus_start();
        if (set_addr) begin
            wr_byte(8'hA0, -1, ack);
            chk({tag, "_dev_ack"}, ack, 1);
            wr_byte(a, -1, ack);
            chk({tag, "_ptr_ack"}, ack, 1);
            m_ptr = a;
            bus_start();
        end
        wr_byte(8'hA1, -1, ack);
        chk({tag, "_rdev_ack"}, ack, 1);
        for (int i = 0; i < n; i++) begin
            rd_byte(i == n - 1, b);
            exp_re.push_back(8'(m_ptr));
            chk({tag, "_rdata"}, b, ref_mem[m_ptr]);
            if (i < n - 1) m_ptr = (m_ptr + 1) % 256;
        end
        chk({tag, "_oe_after_nack"}, bus.IIC_SDA_OE, 0);
        bus_stop();
        check_events(tag);
    endtask

    initial begin
        logic ack, r;
        int   k, op, n;
        logic [7:0] a;

        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
        #1;
        chk("rst_oe", bus.IIC_SDA_OE, 0);
        chk("rst_we", bus.MEM_WE, 0);
        chk("rst_re", bus.MEM_RE, 0);
        chk("rst_addr", bus.MEM_ADDR, 0);
        chk("rst_wd", bus.MEM_WD, 0);
        chk("rst_busy", bus.BUSY_OUT, 0);
        wclk(2);
        rst_n = 1'b1;
        wclk(20);

        // basic write of two bytes, then a current-address read proves pointer = 07
        preload(8'h07, 8'h3C);
        wdat = '{8'h11, 8'h22};
        do_write("t1", 8'h05, -1, 0);
        chk("t1_ptr_model", m_ptr, 8'h07);
        do_read("t1rd", 1'b0, 8'h00, 1);

        // random read via repeated START
        preload(8'h03, 8'h44);
        preload(8'h04, 8'h55);
        do_read("t2", 1'b1, 8'h03, 2);

        // wrong device address: no ACK, no strobes, never busy
        oe_seen = 1'b0; busy_seen = 1'b0; strobe_seen = 1'b0;
        bus_start();
        wr_byte(8'hA4, -1, ack);
        chk("t3_nack", ack, 0);
        wr_byte(8'h5A, -1, ack);
        chk("t3_nack2", ack, 0);
        bus_stop();
        chk("t3_oe_seen", oe_seen, 0);
        chk("t3_busy_seen", busy_seen, 0);
        chk("t3_strobe_seen", strobe_seen, 0);

        // pointer wrap
        wdat = '{8'hA5, 8'h5A};
        do_write("t4", 8'hFF, -1, 0);
        chk("t4_ptr_model", m_ptr, 8'h01);

        // glitch inside a full byte is ignored; byte cut short by STOP is discarded
        wdat = '{8'hC3};
        do_write("t5", 8'h30, 6, 4);

        // reset while driving the read address ACK
        bus_start();
        a = 8'hA1;
        for (int i = 7; i >= 0; i--) bus_bit(a[i], 1'b0, r);
        m_sda = 1'b1;
        k = 0;
        while (!bus.IIC_SDA_OE && k < 200) begin
            wclk(1);
            k++;
        end
        chk("t6_ack_driven", bus.IIC_SDA_OE, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_oe", bus.IIC_SDA_OE, 0);
        chk("t6_rst_busy", bus.BUSY_OUT, 0);
        wclk(5);
        rst_n = 1'b1;
        wclk(10);
        m_scl = 1'b1;
        wclk(T);
        m_ptr = 0;
        got_we.delete(); got_re.delete();
        do_read("t6rd", 1'b0, 8'h00, 1);

        // randomized transactions
        for (int it = 0; it < 3; it++) begin
            op = $urandom_range(0, 2);
            a  = 8'($urandom);
            n  = $urandom_range(1, 2);
            case (op)
                0: begin
                    wdat.delete();
                    for (int j = 0; j < n; j++) wdat.push_back(8'($urandom));
                    do_write("rnd_wr", a, -1, 0);
                end
                1: do_read("rnd_rd", 1'b1, a, n);
                default: do_read("rnd_cur", 1'b0, 8'h00, n);
            endcase
        end

        chk("strobe_rules", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
